// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg: shared definitions for RV32I immediate encode/decode.
// Holds the format enum, error codes, per-format immediate limits, the NOP word
// and the legality check used by both the packer and the error counter.
package rv_imm_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4
    } imm_fmt_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT   = 2'd3;

    localparam int signed I_MIN = -2048;
    localparam int signed I_MAX = 2047;
    localparam int signed B_MIN = -4096;
    localparam int signed B_MAX = 4094;
    localparam int signed J_MIN = -1048576;
    localparam int signed J_MAX = 1048574;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Priority: bad format > alignment > range.
    function automatic logic [1:0] imm_check(input logic [2:0] fmt, input logic [31:0] imm);
        logic signed [31:0] simm;
        logic [1:0]         code;
        simm = imm;
        code = ERR_NONE;
        case (fmt)
            FMT_I, FMT_S: begin
                if (simm < I_MIN || simm > I_MAX) code = ERR_RANGE;
            end
            FMT_B: begin
                if (imm[0])                            code = ERR_ALIGN;
                else if (simm < B_MIN || simm > B_MAX) code = ERR_RANGE;
            end
            FMT_J: begin
                if (imm[0])                            code = ERR_ALIGN;
                else if (simm < J_MIN || simm > J_MAX) code = ERR_RANGE;
            end
            FMT_U: begin
                // Low 12 bits cannot be represented in a U-type word.
                if (imm[11:0] != 12'h000) code = ERR_RANGE;
            end
            default: code = ERR_FMT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational RV32I instruction packer.
// Ports: fmt/imm/opcode/rd/funct3/rs1/rs2 in; instr, err, err_code out.
// Illegal requests produce NOP_INSTR with err set.
module imm_pack
    import rv_imm_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] instr,
    output logic        err,
    output logic [1:0]  err_code
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (fmt)
            FMT_I:   raw = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_U:   raw = {imm[31:12], rd, opcode};
            default: raw = '0;
        endcase
    end

    always_comb begin
        err_code = imm_check(fmt, imm);
        err      = (err_code != ERR_NONE);
        instr    = err ? NOP_INSTR : raw;
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready RV32I instruction packer.
// Ports: clk, reset (sync, active-high); request in_* with in_valid/in_ready;
// result out_instr/out_err/out_err_code with out_valid/out_ready;
// err_count saturating count of accepted illegal requests.
module imm_encoder
    import rv_imm_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [31:0]          in_imm,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [1:0]           out_err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        s1_valid, s2_valid;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_imm;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [2:0]  s1_funct3;

    logic        s1_adv, s2_adv;
    logic [31:0] pk_instr;
    logic        pk_err;
    logic [1:0]  pk_err_code;
    logic        in_illegal;

    // No skid buffer: ready ripples straight back from out_ready.
    always_comb begin
        s2_adv     = !s2_valid || out_ready;
        s1_adv     = !s1_valid || s2_adv;
        in_ready   = s1_adv;
        in_illegal = (imm_check(in_fmt, in_imm) != ERR_NONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_imm    <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_funct3 <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt;
                s1_imm    <= in_imm;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_funct3 <= in_funct3;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
            end
        end
    end

    imm_pack #(
        .NOP_INSTR (NOP_INSTR)
    ) u_pack (
        .fmt      (s1_fmt),
        .imm      (s1_imm),
        .opcode   (s1_opcode),
        .rd       (s1_rd),
        .funct3   (s1_funct3),
        .rs1      (s1_rs1),
        .rs2      (s1_rs2),
        .instr    (pk_instr),
        .err      (pk_err),
        .err_code (pk_err_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid     <= 1'b0;
            out_instr    <= '0;
            out_err      <= 1'b0;
            out_err_code <= ERR_NONE;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_instr    <= pk_instr;
                out_err      <= pk_err;
                out_err_code <= pk_err_code;
            end
        end
    end

    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (in_valid && in_ready && in_illegal &&
                     (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed bench for imm_encoder with an expected-result queue.
module tb_imm_encoder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    logic        clk, reset;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr;
    logic [1:0]  out_err_code;
    logic [15:0] err_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    bit   mon_en   = 1'b1;
    exp_t sb[$];

    imm_encoder #(
        .ERR_CNT_W (16),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_fmt       (in_fmt),
        .in_imm       (in_imm),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_funct3    (in_funct3),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_err      (out_err),
        .out_err_code (out_err_code),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_i(input logic [11:0] imm, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Monitor: compare every output handshake with the head of the queue.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed %0h expected none", out_instr);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_err", {31'b0, out_err}, {31'b0, e.err});
                chk("out_err_code", {30'b0, out_err_code}, {30'b0, e.code});
                n_out++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] fmt, input logic [31:0] imm, input logic [6:0] op,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] ei, input logic ee,
                        input logic [1:0] ec);
        bit got;
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_imm    = imm;
        in_opcode = op;
        in_rd     = rd;
        in_funct3 = f3;
        in_rs1    = rs1;
        in_rs2    = rs2;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else @(posedge clk);
        end
        chk("accept_timeout", {31'b0, got}, 32'd1);
        @(posedge clk);
        sb.push_back('{instr: ei, err: ee, code: ec});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        logic [31:0] held;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_imm = '0; in_opcode = '0; in_rd = '0;
        in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_err_code", {30'b0, out_err_code}, 32'd0);
        chk("rst_err_count", {16'b0, err_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // I-type plus latency
        send(3'd0, -32'sd1, 7'b0010011, 5'd5, 3'd0, 5'd1, 5'd0, 32'hFFF0_8293, 1'b0, 2'd0);
        chk("lat_s1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_s2", {31'b0, out_valid}, 32'd1);

        send(3'd2, -32'sd4096, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 32'h8020_8063, 1'b0, 2'd0);
        send(3'd2, 32'd4094, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 32'h7E20_8FE3, 1'b0, 2'd0);
        send(3'd2, 32'd3, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, NOP, 1'b1, 2'd2);
        chk("err_count_b", {16'b0, err_count}, 32'd1);
        send(3'd3, 32'd2048, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0010_00EF, 1'b0, 2'd0);
        send(3'd3, 32'd1048576, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, NOP, 1'b1, 2'd1);
        send(3'd4, 32'h1234_5000, 7'b0110111, 5'd10, 3'd0, 5'd0, 5'd0, 32'h1234_5537, 1'b0, 2'd0);
        send(3'd4, 32'h1234_5001, 7'b0110111, 5'd10, 3'd0, 5'd0, 5'd0, NOP, 1'b1, 2'd1);
        send(3'd7, 32'h1234_5000, 7'b0110111, 5'd10, 3'd0, 5'd0, 5'd0, NOP, 1'b1, 2'd3);
        chk("err_count_4", {16'b0, err_count}, 32'd4);
        drain();

        // Backpressure: 8 back-to-back requests, out_ready low for 5 cycles
        n_out = 0;
        t0 = cyc;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] im;
                    im = i * 100 - 300;
                    send(3'd0, im, 7'b0010011, 5'(i + 1), 3'(i), 5'(i + 2), 5'd0,
                         model_i(im[11:0], 5'(i + 2), 3'(i), 5'(i + 1)), 1'b0, 2'd0);
                end
                chk("full_rate_cycles", cyc - t0, 32'd13);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = out_instr;
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_stable", out_instr, held);
                end
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", n_out, 32'd8);

        // Reset with both stages full
        out_ready = 1'b0;
        send(3'd6, 32'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, NOP, 1'b1, 2'd3);
        send(3'd6, 32'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, NOP, 1'b1, 2'd3);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_count", {16'b0, err_count}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_stale", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Counter saturation: 70000 illegal requests at full rate
        mon_en = 1'b0;
        in_fmt = 3'd7;
        in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("cnt_fffe", {16'b0, err_count}, 32'h0000_FFFE);
        in_valid = 1'b1;
        repeat (4466) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("cnt_sat", {16'b0, err_count}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
